// File: rtl/tdc_echo_pkg.sv
// Shared types and default sizing for the TDC echo pairing block.
package tdc_echo_pkg;
    localparam int DEF_DW         = 24;
    localparam int DEF_WW         = 16;
    localparam int DEF_MIN_WIDTH  = 4;
    localparam int DEF_MAX_WIDTH  = 20000;
    localparam int DEF_MAX_ECHO   = 3;
    localparam int DEF_FIFO_DEPTH = 16;
    localparam int DEF_CW         = 16;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WAIT_SYNC = 2'd1;
    localparam logic [1:0] S_RUN       = 2'd2;

    typedef struct packed {
        logic [DEF_DW-1:0] rise;
        logic [DEF_WW-1:0] width;
        logic [1:0]        idx;
    } echo_t;
endpackage

// File: rtl/tdc_echo_fifo.sv
// Show-ahead FIFO: head word visible whenever not empty; a pop frees room for a same-cycle push.
module tdc_echo_fifo #(
    parameter int W     = 42,
    parameter int DEPTH = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_flush,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_wdata,
    output logic [W-1:0] o_rdata,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
    logic         do_push, do_pop;

    assign o_empty = (wr_q == rd_q);
    assign o_full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign o_rdata = mem[rd_q[AW-1:0]];

    always_comb begin
        do_pop  = i_pop && !o_empty;
        do_push = i_push && !i_flush && (!o_full || do_pop);
        wr_d    = wr_q;
        rd_d    = rd_q;
        if (i_flush) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + (AW+1)'(1);
            if (do_pop)  rd_d = rd_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage carries no reset so it can map onto distributed RAM.
    always_ff @(posedge i_clk) begin
        if (do_push) mem[wr_q[AW-1:0]] <= i_wdata;
    end
endmodule

// File: rtl/tdc_echo_pair_proc.sv
// Pairs TDC rise/fall stops into qualified, slot-indexed echoes and queues them for the distance stage.
module tdc_echo_pair_proc
    import tdc_echo_pkg::*;
#(
    parameter int DW         = DEF_DW,
    parameter int WW         = DEF_WW,
    parameter int MIN_WIDTH  = DEF_MIN_WIDTH,
    parameter int MAX_WIDTH  = DEF_MAX_WIDTH,
    parameter int MAX_ECHO   = DEF_MAX_ECHO,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int CW         = DEF_CW
) (
    input  logic          i_clk_100m,
    input  logic          i_rst_n,
    input  logic          i_motor_state,
    input  logic          i_angle_sync,
    input  logic          i_tdc_new_sig,
    input  logic [DW-1:0] i_rise_data,
    input  logic [DW-1:0] i_fall_data,
    input  logic          i_tdc_err_sig,
    input  logic          i_echo_ready,
    output logic          o_echo_valid,
    output logic [DW-1:0] o_echo_rise,
    output logic [WW-1:0] o_echo_width,
    output logic [1:0]    o_echo_idx,
    output logic [CW-1:0] o_drop_cnt,
    output logic [CW-1:0] o_err_cnt,
    output logic          o_run
);
    localparam int EW = DW + WW + 2;

    logic [1:0]    state_q, state_d;
    logic          sync_q;
    logic          s1_vld_q, s1_vld_d, s1_err_q, s1_err_d;
    logic [DW-1:0] s1_rise_q, s1_rise_d, s1_fall_q, s1_fall_d;
    logic          s2_vld_q, s2_vld_d, s2_err_q, s2_err_d;
    logic [DW-1:0] s2_rise_q, s2_rise_d;
    logic [WW-1:0] s2_width_q, s2_width_d;
    logic [2:0]    slot_q, slot_d, slot_base;
    logic [CW-1:0] drop_q, drop_d, err_q, err_d;
    logic [DW-1:0] diff;
    logic          flush, sync_edge, accept, qual, room;
    logic          drop_evt, err_evt;
    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [EW-1:0] fifo_rdata;

    always_comb begin
        flush     = !i_motor_state;
        sync_edge = i_angle_sync && !sync_q;

        state_d = state_q;
        if (flush)                                       state_d = S_IDLE;
        else if (state_q == S_IDLE)                      state_d = S_WAIT_SYNC;
        else if (state_q == S_WAIT_SYNC && sync_edge)    state_d = S_RUN;

        // The strobe coinciding with the RUN-entering edge already belongs to the new slot.
        accept = i_tdc_new_sig && i_motor_state &&
                 (state_q == S_RUN || (state_q == S_WAIT_SYNC && sync_edge));
        s1_vld_d  = accept;
        s1_rise_d = accept ? i_rise_data   : s1_rise_q;
        s1_fall_d = accept ? i_fall_data   : s1_fall_q;
        s1_err_d  = accept ? i_tdc_err_sig : s1_err_q;

        diff       = s1_fall_q - s1_rise_q;
        s2_vld_d   = s1_vld_q && !flush;
        s2_rise_d  = s1_vld_q ? s1_rise_q : s2_rise_q;
        s2_err_d   = s1_vld_q ? s1_err_q  : s2_err_q;
        s2_width_d = s2_width_q;
        if (s1_vld_q) s2_width_d = (|diff[DW-1:WW]) ? '1 : diff[WW-1:0];

        qual = s2_vld_q && !s2_err_q &&
               (s2_width_q >= WW'(MIN_WIDTH)) && (s2_width_q <= WW'(MAX_WIDTH));
        slot_base = sync_edge ? 3'd0 : slot_q;
        room      = slot_base < 3'(MAX_ECHO);
        fifo_pop  = o_echo_valid && i_echo_ready;
        fifo_push = !flush && qual && room && (!fifo_full || fifo_pop);
        drop_evt  = !flush && qual && (!room || (fifo_full && !fifo_pop));
        err_evt   = !flush && s2_vld_q && !qual;

        slot_d = slot_base;
        if (flush)             slot_d = 3'd0;
        else if (qual && room) slot_d = slot_base + 3'd1;

        drop_d = drop_q;
        if (drop_evt && drop_q != '1) drop_d = drop_q + CW'(1);
        err_d = err_q;
        if (err_evt && err_q != '1) err_d = err_q + CW'(1);
    end

    always_ff @(posedge i_clk_100m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            sync_q     <= 1'b0;
            s1_vld_q   <= 1'b0;
            s1_err_q   <= 1'b0;
            s1_rise_q  <= '0;
            s1_fall_q  <= '0;
            s2_vld_q   <= 1'b0;
            s2_err_q   <= 1'b0;
            s2_rise_q  <= '0;
            s2_width_q <= '0;
            slot_q     <= '0;
            drop_q     <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            sync_q     <= i_angle_sync;
            s1_vld_q   <= s1_vld_d;
            s1_err_q   <= s1_err_d;
            s1_rise_q  <= s1_rise_d;
            s1_fall_q  <= s1_fall_d;
            s2_vld_q   <= s2_vld_d;
            s2_err_q   <= s2_err_d;
            s2_rise_q  <= s2_rise_d;
            s2_width_q <= s2_width_d;
            slot_q     <= slot_d;
            drop_q     <= drop_d;
            err_q      <= err_d;
        end
    end

    tdc_echo_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk   (i_clk_100m),
        .i_rst_n (i_rst_n),
        .i_flush (flush),
        .i_push  (fifo_push),
        .i_pop   (fifo_pop),
        .i_wdata ({s2_rise_q, s2_width_q, slot_base[1:0]}),
        .o_rdata (fifo_rdata),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    assign o_echo_valid = !fifo_empty;
    assign o_echo_rise  = o_echo_valid ? fifo_rdata[EW-1 -: DW] : '0;
    assign o_echo_width = o_echo_valid ? fifo_rdata[WW+1 -: WW] : '0;
    assign o_echo_idx   = o_echo_valid ? fifo_rdata[1:0]        : '0;
    assign o_drop_cnt   = drop_q;
    assign o_err_cnt    = err_q;
    assign o_run        = (state_q == S_RUN);
endmodule

// File: tb/tb_tdc_echo_pair_proc.sv
// Randomized and directed bench for tdc_echo_pair_proc against a queue-based reference model.
module tb_tdc_echo_pair_proc;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        motor = 1'b0, sync = 1'b0, new_sig = 1'b0, err_sig = 1'b0, ready = 1'b0;
    logic [23:0] rise = '0, fall = '0;
    logic        o_valid, o_run;
    logic [23:0] o_rise;
    logic [15:0] o_width, o_drop, o_err;
    logic [1:0]  o_idx;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tdc_echo_pair_proc dut (
        .i_clk_100m   (clk),
        .i_rst_n      (rst_n),
        .i_motor_state(motor),
        .i_angle_sync (sync),
        .i_tdc_new_sig(new_sig),
        .i_rise_data  (rise),
        .i_fall_data  (fall),
        .i_tdc_err_sig(err_sig),
        .i_echo_ready (ready),
        .o_echo_valid (o_valid),
        .o_echo_rise  (o_rise),
        .o_echo_width (o_width),
        .o_echo_idx   (o_idx),
        .o_drop_cnt   (o_drop),
        .o_err_cnt    (o_err),
        .o_run        (o_run)
    );

    typedef struct { logic [23:0] rise; int width; int idx; } echo_s;
    typedef struct { logic [23:0] rise; logic [23:0] fall; bit err; int due; } strobe_s;

    echo_s   exp_q[$];
    strobe_s pend[$];
    int      m_phase = 0;   // 0 idle, 1 waiting for first sync, 2 running
    int      m_slot = 0, m_drop = 0, m_err = 0, cyc = 0;
    bit      m_prev_sync = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_outputs();
        chk("valid", 32'(o_valid), 32'(exp_q.size() > 0));
        chk("run", 32'(o_run), 32'(m_phase == 2));
        chk("drop_cnt", 32'(o_drop), 32'(m_drop));
        chk("err_cnt", 32'(o_err), 32'(m_err));
        if (exp_q.size() > 0) begin
            chk("rise", 32'(o_rise), 32'(exp_q[0].rise));
            chk("width", 32'(o_width), 32'(exp_q[0].width));
            chk("idx", 32'(o_idx), 32'(exp_q[0].idx));
        end
    endtask

    // Reference behaviour for one clock, given the inputs about to be sampled.
    task automatic model_step();
        bit          sync_rise;
        strobe_s     p;
        logic [23:0] d;
        int          w;
        sync_rise   = sync && !m_prev_sync;
        m_prev_sync = sync;
        if (!motor) begin
            m_phase = 0;
            m_slot  = 0;
            exp_q.delete();
            pend.delete();
        end else begin
            if (ready && exp_q.size() > 0) void'(exp_q.pop_front());
            if (sync_rise) m_slot = 0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                p = pend.pop_front();
                d = p.fall - p.rise;
                w = (d > 24'd65535) ? 65535 : int'(d);
                if (p.err || w < 4 || w > 20000) begin
                    if (m_err < 65535) m_err++;
                end else if (m_slot >= 3) begin
                    if (m_drop < 65535) m_drop++;
                end else begin
                    if (exp_q.size() < 16) exp_q.push_back('{p.rise, w, m_slot});
                    else if (m_drop < 65535) m_drop++;
                    m_slot++;
                end
            end
            if (new_sig && (m_phase == 2 || (m_phase == 1 && sync_rise)))
                pend.push_back('{rise, fall, err_sig, cyc + 2});
            if (m_phase == 0) m_phase = 1;
            else if (m_phase == 1 && sync_rise) m_phase = 2;
        end
        cyc++;
    endtask

    task automatic tick();
        check_outputs();
        model_step();
        @(negedge clk);
        new_sig = 1'b0;
        err_sig = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic strobe(input logic [23:0] r, input logic [23:0] f, input bit e);
        new_sig = 1'b1;
        rise    = r;
        fall    = f;
        err_sig = e;
        tick();
    endtask

    task automatic new_slot();
        sync = 1'b0;
        tick();
        sync = 1'b1;
    endtask

    initial begin
        int d0;
        int wsel;
        logic [23:0] r;
        logic [23:0] w24;
        @(negedge clk);
        @(negedge clk);
        check_outputs();
        rst_n = 1'b1;

        // Basic echo and one-cycle pop
        motor = 1'b1;
        ready = 1'b1;
        ticks(2);
        sync = 1'b1;
        tick();
        strobe(24'd1000, 24'd1500, 1'b0);
        ticks(5);

        // Wrapped width, then a too-narrow pulse
        strobe(24'hFFFFF0, 24'h000010, 1'b0);
        strobe(24'd5000, 24'd5002, 1'b0);
        ticks(5);

        // Five echoes in one slot, then one in the next slot
        ready = 1'b0;
        new_slot();
        for (int i = 0; i < 5; i++) strobe(24'(100 * i), 24'(100 * i + 50), 1'b0);
        ticks(4);
        new_slot();
        strobe(24'd7777, 24'd7877, 1'b0);
        ticks(4);
        ready = 1'b1;
        ticks(8);

        // Eighteen echoes over six slots into a stalled FIFO
        ready = 1'b0;
        d0 = m_drop;
        for (int s = 0; s < 6; s++) begin
            new_slot();
            for (int k = 0; k < 3; k++) strobe(24'(s * 16 + k * 5), 24'(s * 16 + k * 5 + 10), 1'b0);
        end
        ticks(4);
        chk("drop_full", 32'(o_drop), 32'(d0 + 2));
        ready = 1'b1;
        ticks(20);

        // TDC error flag and boundary widths 4 and 20000/20001
        strobe(24'd10, 24'd200, 1'b1);
        new_slot();
        strobe(24'd10, 24'd14, 1'b0);
        strobe(24'd10, 24'd20010, 1'b0);
        strobe(24'd10, 24'd20011, 1'b0);
        ticks(5);

        // Motor loses lock with queued echoes, then re-lock
        ready = 1'b0;
        new_slot();
        for (int i = 0; i < 3; i++) strobe(24'(i), 24'(i + 40), 1'b0);
        new_slot();
        for (int i = 0; i < 2; i++) strobe(24'(i), 24'(i + 60), 1'b0);
        ticks(3);
        motor = 1'b0;
        sync  = 1'b0;
        tick();
        chk("flushed", 32'(o_valid), 32'd0);
        motor = 1'b1;
        ticks(2);
        strobe(24'd300, 24'd400, 1'b0);
        sync = 1'b1;
        strobe(24'd500, 24'd650, 1'b0);
        ready = 1'b1;
        ticks(5);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            motor = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 7) == 0) sync = ~sync;
            ready = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 1) == 1) begin
                r    = 24'($urandom);
                wsel = int'($urandom_range(0, 5));
                case (wsel)
                    0: w24 = 24'($urandom_range(0, 10));
                    1: w24 = 24'($urandom_range(3, 5));
                    2: w24 = 24'($urandom_range(19998, 20002));
                    3: w24 = 24'($urandom_range(0, 70000));
                    4: w24 = 24'($urandom);
                    default: w24 = 24'($urandom_range(100, 5000));
                endcase
                strobe(r, r + w24, ($urandom_range(0, 9) == 0));
            end else begin
                tick();
            end
        end
        motor = 1'b1;
        ready = 1'b1;
        ticks(25);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
